// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator side of the data-memory interface for the multicycle RV32I
//   datapath. Accepts one load/store request per instruction and drives
//   word-addressed read/write strobes. Sub-word stores are done as
//   read-modify-write. Load data is lane-aligned and sign/zero extended.
//
// Ports
//   clk, reset           clock (rising edge), async active-high reset
//   start                request strobe, sampled only in IDLE
//   is_store             1 = store, 0 = load
//   funct3               RV32I width/sign encoding
//   addr                 byte address
//   wdata                store data (low byte/half used for sb/sh)
//   busy                 high in every state except IDLE
//   done                 one-cycle completion pulse
//   err                  misaligned / out-of-range / illegal funct3, valid with done
//   rdata                load result, held until next successful load
//   mem_addr             word index of the captured request
//   mem_re, mem_we       memory read / write strobes
//   mem_wdata            full word written to memory
//   mem_rdata            memory word, valid the cycle after mem_re
module load_store_unit #(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          is_store,
    input  logic [2:0]    funct3,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [31:0]   rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        DONE
    } state_t;

    state_t      state;
    logic        st_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] wd_q;

    logic        req_bad;
    logic [31:0] shifted;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Request legality, evaluated on the live inputs at acceptance.
    always_comb begin
        req_bad = 1'b0;
        if (addr[31:AW+2] != '0)
            req_bad = 1'b1;
        if (funct3[1:0] == 2'b01 && addr[0])
            req_bad = 1'b1;
        if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
            req_bad = 1'b1;
        if (!is_store && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111))
            req_bad = 1'b1;
        if (is_store && funct3 >= 3'b011)
            req_bad = 1'b1;
    end

    // Load lane extraction and store lane merge on the returned word.
    always_comb begin
        shifted  = mem_rdata >> {off_q, 3'b000};
        load_val = mem_rdata;
        case (f3_q)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_val = {24'h000000, shifted[7:0]};
            3'b101:  load_val = {16'h0000, shifted[15:0]};
            default: load_val = mem_rdata;
        endcase

        merged = mem_rdata;
        case (f3_q[1:0])
            2'b00:   merged[{off_q, 3'b000} +: 8]         = wd_q[7:0];
            2'b01:   merged[{off_q[1], 4'b0000} +: 16]    = wd_q[15:0];
            default: merged = wd_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            rdata     <= '0;
            mem_wdata <= '0;
            mem_addr  <= '0;
            st_q      <= 1'b0;
            f3_q      <= '0;
            off_q     <= '0;
            wd_q      <= '0;
        end else begin
            done   <= 1'b0;
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        st_q     <= is_store;
                        f3_q     <= funct3;
                        off_q    <= addr[1:0];
                        wd_q     <= wdata;
                        mem_addr <= addr[AW+1:2];
                        err      <= req_bad;
                        busy     <= 1'b1;
                        if (req_bad) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (is_store && funct3 == 3'b010) begin
                            state     <= WRITE;
                            mem_we    <= 1'b1;
                            mem_wdata <= wdata;
                        end else begin
                            state  <= READ;
                            mem_re <= 1'b1;
                        end
                    end
                end
                READ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (st_q) begin
                        mem_wdata <= merged;
                        mem_we    <= 1'b1;
                        state     <= WRITE;
                    end else begin
                        rdata <= load_val;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                WRITE: begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int AW    = 5;
    localparam int DEPTH = 2 ** AW;

    logic          clk;
    logic          reset;
    logic          start;
    logic          is_store;
    logic [2:0]    funct3;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [31:0]   rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    int n_cmp;
    int n_err;

    // Environment memory (what the DUT talks to) and the reference image.
    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_rdata;
    logic [31:0] last_wdata;
    int          re_cnt;
    int          we_cnt;

    load_store_unit #(.AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_store  (is_store),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re) begin
            mem_rdata <= mem[mem_addr];
            re_cnt    <= re_cnt + 1;
        end
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            last_wdata    <= mem_wdata;
            we_cnt        <= we_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: access size from funct3, legality from plain
    // arithmetic on the byte address, data from shifts and masks.
    task automatic predict(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output logic e, output int lat,
                           output int nre, output int nwe);
        int unsigned sz;
        int unsigned lane;
        int unsigned idx;
        logic [31:0] w;
        logic [31:0] part;
        logic [31:0] mask;
        sz = 0;
        if (st) begin
            case (f3)
                3'd0: sz = 1;
                3'd1: sz = 2;
                3'd2: sz = 4;
                default: sz = 0;
            endcase
        end else begin
            case (f3)
                3'd0, 3'd4: sz = 1;
                3'd1, 3'd5: sz = 2;
                3'd2:       sz = 4;
                default:    sz = 0;
            endcase
        end
        e = (sz == 0) || (a >= 32'(4 * DEPTH));
        if (sz != 0 && (a % sz) != 0)
            e = 1'b1;
        nre = 0;
        nwe = 0;
        lat = 1;
        if (e)
            return;
        idx  = a / 4;
        lane = a % 4;
        w    = ref_mem[idx];
        if (!st) begin
            lat = 3;
            nre = 1;
            if (sz == 1) begin
                part = (w >> (8 * lane)) & 32'h000000FF;
                if (f3 == 3'd0 && part >= 32'd128)
                    part = part - 32'd256;
            end else if (sz == 2) begin
                part = (w >> (8 * lane)) & 32'h0000FFFF;
                if (f3 == 3'd1 && part >= 32'd32768)
                    part = part - 32'd65536;
            end else begin
                part = w;
            end
            exp_rdata = part;
        end else begin
            nwe = 1;
            if (sz == 4) begin
                lat = 2;
                ref_mem[idx] = wd;
            end else begin
                lat  = 4;
                nre  = 1;
                mask = ((sz == 1) ? 32'h000000FF : 32'h0000FFFF) << (8 * lane);
                ref_mem[idx] = (w & ~mask) | ((wd << (8 * lane)) & mask);
            end
        end
    endtask

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input string tag);
        logic        e;
        int          lat_exp;
        int          nre;
        int          nwe;
        int          lat;
        int          re0;
        int          we0;
        logic [31:0] a_cp;
        a_cp = a;
        predict(st, f3, a, wd, e, lat_exp, nre, nwe);
        re0 = re_cnt;
        we0 = we_cnt;
        @(negedge clk);
        start    = 1'b1;
        is_store = st;
        funct3   = f3;
        addr     = a;
        wdata    = wd;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(lat_exp));
        check({tag, " err"}, {31'd0, err}, {31'd0, e});
        check({tag, " rdata"}, rdata, exp_rdata);
        check({tag, " mem_re count"}, 32'(re_cnt - re0), 32'(nre));
        check({tag, " mem_we count"}, 32'(we_cnt - we0), 32'(nwe));
        check({tag, " mem_addr"}, {27'd0, mem_addr}, {27'd0, a_cp[AW+1:2]});
        if (st && !e)
            check({tag, " written word"}, last_wdata, ref_mem[a_cp[AW+1:2]]);
        @(posedge clk);
        #1;
        check({tag, " idle busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] saved;
        int          we0;
        int          re0;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;

        n_cmp      = 0;
        n_err      = 0;
        re_cnt     = 0;
        we_cnt     = 0;
        last_wdata = '0;
        mem_rdata  = '0;
        exp_rdata  = '0;
        start      = 1'b0;
        is_store   = 1'b0;
        funct3     = '0;
        addr       = '0;
        wdata      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[2]     = 32'h8899AABB;
        ref_mem[2] = 32'h8899AABB;

        reset = 1'b1;
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset err", {31'd0, err}, 32'd0);
        check("reset mem_re", {31'd0, mem_re}, 32'd0);
        check("reset mem_we", {31'd0, mem_we}, 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset mem_wdata", mem_wdata, 32'd0);
        check("reset mem_addr", {27'd0, mem_addr}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Loads from a known word
        do_req(1'b0, 3'b000, 32'h0B, 32'h0, "lb 0x0B");
        check("lb literal", rdata, 32'hFFFFFF88);
        do_req(1'b0, 3'b100, 32'h0B, 32'h0, "lbu 0x0B");
        check("lbu literal", rdata, 32'h00000088);
        do_req(1'b0, 3'b001, 32'h0A, 32'h0, "lh 0x0A");
        check("lh literal", rdata, 32'hFFFF8899);
        do_req(1'b0, 3'b101, 32'h08, 32'h0, "lhu 0x08");
        check("lhu literal", rdata, 32'h0000AABB);
        do_req(1'b0, 3'b010, 32'h08, 32'h0, "lw 0x08");
        check("lw literal", rdata, 32'h8899AABB);

        // Sub-word stores via read-modify-write
        do_req(1'b1, 3'b000, 32'h09, 32'h12345677, "sb 0x09");
        check("sb literal word", last_wdata, 32'h889977BB);
        do_req(1'b1, 3'b001, 32'h0A, 32'h0000CAFE, "sh 0x0A");
        check("sh literal word", mem[2], 32'hCAFE77BB);
        do_req(1'b1, 3'b010, 32'h0C, 32'hDEADBEEF, "sw 0x0C");
        do_req(1'b0, 3'b010, 32'h0C, 32'h0, "lw 0x0C");

        // Error cases
        do_req(1'b0, 3'b010, 32'h06, 32'h0, "lw misaligned");
        do_req(1'b1, 3'b001, 32'h03, 32'h1111, "sh misaligned");
        do_req(1'b0, 3'b010, 32'h80, 32'h0, "lw out of range");
        do_req(1'b0, 3'b011, 32'h10, 32'h0, "load f3 011");
        do_req(1'b1, 3'b100, 32'h10, 32'h0, "store f3 100");
        do_req(1'b0, 3'b000, 32'h7F, 32'h0, "lb top byte");

        // Reset during the WAIT state of an sb
        saved = mem[4];
        we0   = we_cnt;
        @(negedge clk);
        start    = 1'b1;
        is_store = 1'b1;
        funct3   = 3'b000;
        addr     = 32'h11;
        wdata    = 32'h000000A5;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("abort busy before reset", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort mem_we", {31'd0, mem_we}, 32'd0);
        check("abort rdata", rdata, 32'd0);
        check("abort mem_wdata", mem_wdata, 32'd0);
        check("abort mem_addr", {27'd0, mem_addr}, 32'd0);
        exp_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort no write", 32'(we_cnt - we0), 32'd0);
        check("abort mem intact", mem[4], saved);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, "lw after abort");

        // start held through busy, then accepted from IDLE after done
        re0 = re_cnt;
        @(negedge clk);
        start    = 1'b1;
        is_store = 1'b0;
        funct3   = 3'b010;
        addr     = 32'h10;
        wdata    = 32'h0;
        @(posedge clk);
        #1;
        addr = 32'h14;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("held first done", {31'd0, done}, 32'd1);
        check("held first rdata", rdata, ref_mem[4]);
        check("held single read", 32'(re_cnt - re0), 32'd1);
        @(posedge clk);
        #1;
        check("held idle busy", {31'd0, busy}, 32'd0);
        check("held idle mem_re", {31'd0, mem_re}, 32'd0);
        @(posedge clk);
        #1;
        check("held second mem_re", {31'd0, mem_re}, 32'd1);
        check("held second mem_addr", {27'd0, mem_addr}, 32'd5);
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("held second done", {31'd0, done}, 32'd1);
        check("held second rdata", rdata, ref_mem[5]);
        exp_rdata = ref_mem[5];
        @(posedge clk);
        #1;

        // Randomized requests against the reference model
        for (int unsigned i = 0; i < 40; i++) begin
            st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0)
                f3 = 3'($urandom_range(0, 7));
            else if (st)
                f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end
            if ($urandom_range(0, 9) == 0)
                a = $urandom;
            else
                a = 32'($urandom_range(0, 4 * DEPTH - 1));
            do_req(st, f3, a, $urandom, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
